// File: rtl/chip8_sprite_engine.sv
// CHIP-8 sprite engine: performs DXYN XOR-draws and 00E0 clears on the 64x32 1bpp
// framebuffer through the shared memory's GPU port, reporting done and VF collision.
module chip8_sprite_engine #(
  parameter int unsigned       ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] FB_BASE = 12'hF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [7:0]        pos_x,
  input  logic [7:0]        pos_y,
  input  logic [3:0]        rows,
  input  logic [ADDR_W-1:0] sprite_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              gpu_read,
  output logic [ADDR_W-1:0] gpu_read_addr,
  input  logic [7:0]        gpu_read_data,
  input  logic              gpu_read_ack,
  output logic              gpu_write,
  output logic [ADDR_W-1:0] gpu_write_addr,
  output logic [7:0]        gpu_write_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_SPR_RD, S_SPR_WT, S_L_RD, S_L_WT, S_L_WR,
    S_R_RD, S_R_WT, S_R_WR, S_CLR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        col_q, col_d, sh_q, sh_d;
  logic [4:0]        y0_q, y0_d;
  logic [3:0]        rows_q, rows_d, row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        spr_q, spr_d, fb_q, fb_d, byte_q, byte_d;
  logic              busy_q, busy_d, done_q, done_d, coll_q, coll_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [15:0]       shift_d;

  // A row is finished (no access) once r reaches the height or falls below the bottom edge.
  function automatic logic row_clipped(input logic [3:0] r, input logic [3:0] n,
                                       input logic [4:0] y0);
    logic [5:0] y;
    y = {1'b0, y0} + {2'b00, r};
    row_clipped = (r >= n) || (y > 6'd31);
  endfunction

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [4:0] y0, input logic [3:0] r,
                                                input logic [2:0] c);
    logic [4:0] y;
    y = y0 + {1'b0, r};
    fb_addr = FB_BASE + {{(ADDR_W-8){1'b0}}, y, c};
  endfunction

  // Next-state logic, then registered strobes/addresses derived from the next state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    sh_d    = sh_q;
    y0_d    = y0_q;
    rows_d  = rows_q;
    row_d   = row_q;
    base_d  = base_q;
    spr_d   = spr_q;
    fb_d    = fb_q;
    byte_d  = byte_q;
    coll_d  = coll_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = pos_x[5:3];
          sh_d    = pos_x[2:0];
          y0_d    = pos_y[4:0];
          rows_d  = rows;
          base_d  = sprite_addr;
          row_d   = 4'd0;
          coll_d  = 1'b0;
          state_d = S_SPR_RD;
        end else if (clear) begin
          byte_d  = 8'd0;
          coll_d  = 1'b0;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SPR_RD: state_d = row_clipped(row_q, rows_q, y0_q) ? S_DONE : S_SPR_WT;
      S_SPR_WT: begin
        if (gpu_read_ack) begin
          spr_d   = gpu_read_data;
          state_d = S_L_RD;
        end else begin
          state_d = S_SPR_WT;
        end
      end
      S_L_RD: state_d = S_L_WT;
      S_L_WT: begin
        if (gpu_read_ack) begin
          fb_d    = gpu_read_data;
          state_d = S_L_WR;
        end else begin
          state_d = S_L_WT;
        end
      end
      S_L_WR: begin
        // Unaligned sprites spill into the next byte unless already at the right edge.
        if ((sh_q == 3'd0) || (col_q == 3'd7)) begin
          row_d   = row_q + 4'd1;
          state_d = S_SPR_RD;
        end else begin
          state_d = S_R_RD;
        end
      end
      S_R_RD: state_d = S_R_WT;
      S_R_WT: begin
        if (gpu_read_ack) begin
          fb_d    = gpu_read_data;
          state_d = S_R_WR;
        end else begin
          state_d = S_R_WT;
        end
      end
      S_R_WR: begin
        row_d   = row_q + 4'd1;
        state_d = S_SPR_RD;
      end
      S_CLR: begin
        if (byte_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          byte_d  = byte_q + 8'd1;
          state_d = S_CLR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    shift_d   = {spr_d, 8'h00} >> sh_d;
    rd_d      = 1'b0;
    rd_addr_d = {ADDR_W{1'b0}};
    wr_d      = 1'b0;
    wr_addr_d = {ADDR_W{1'b0}};
    wr_data_d = 8'h00;
    case (state_d)
      S_SPR_RD: begin
        if (!row_clipped(row_d, rows_d, y0_d)) begin
          rd_d      = 1'b1;
          rd_addr_d = base_d + {{(ADDR_W-4){1'b0}}, row_d};
        end else begin
          rd_d      = 1'b0;
        end
      end
      S_L_RD: begin
        rd_d      = 1'b1;
        rd_addr_d = fb_addr(y0_d, row_d, col_d);
      end
      S_R_RD: begin
        rd_d      = 1'b1;
        rd_addr_d = fb_addr(y0_d, row_d, col_d + 3'd1);
      end
      S_L_WR: begin
        wr_d      = 1'b1;
        wr_addr_d = fb_addr(y0_d, row_d, col_d);
        wr_data_d = fb_d ^ shift_d[15:8];
        coll_d    = coll_d | (|(fb_d & shift_d[15:8]));
      end
      S_R_WR: begin
        wr_d      = 1'b1;
        wr_addr_d = fb_addr(y0_d, row_d, col_d + 3'd1);
        wr_data_d = fb_d ^ shift_d[7:0];
        coll_d    = coll_d | (|(fb_d & shift_d[7:0]));
      end
      S_CLR: begin
        wr_d      = 1'b1;
        wr_addr_d = FB_BASE + {{(ADDR_W-8){1'b0}}, byte_d};
        wr_data_d = 8'h00;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= 3'd0;
      sh_q      <= 3'd0;
      y0_q      <= 5'd0;
      rows_q    <= 4'd0;
      row_q     <= 4'd0;
      base_q    <= {ADDR_W{1'b0}};
      spr_q     <= 8'h00;
      fb_q      <= 8'h00;
      byte_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      coll_q    <= 1'b0;
      rd_q      <= 1'b0;
      rd_addr_q <= {ADDR_W{1'b0}};
      wr_q      <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      sh_q      <= sh_d;
      y0_q      <= y0_d;
      rows_q    <= rows_d;
      row_q     <= row_d;
      base_q    <= base_d;
      spr_q     <= spr_d;
      fb_q      <= fb_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      coll_q    <= coll_d;
      rd_q      <= rd_d;
      rd_addr_q <= rd_addr_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign collision      = coll_q;
  assign gpu_read       = rd_q;
  assign gpu_read_addr  = rd_addr_q;
  assign gpu_write      = wr_q;
  assign gpu_write_addr = wr_addr_q;
  assign gpu_write_data = wr_data_q;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Directed self-checking bench for chip8_sprite_engine with a 1-cycle-ack 4 KiB memory.
module tb_chip8_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  pos_x = 8'd0;
  logic [7:0]  pos_y = 8'd0;
  logic [3:0]  rows = 4'd0;
  logic [11:0] sprite_addr = 12'd0;
  logic        busy, done, collision, gpu_read, gpu_write;
  logic [11:0] gpu_read_addr, gpu_write_addr;
  logic [7:0]  gpu_write_data;
  logic [7:0]  rdata_r = 8'h00;
  logic        ack_r = 1'b0;

  logic [7:0]  mem [0:4095];
  int          cyc = 0, rd_count = 0, wr_count = 0, both_count = 0, seq_err = 0, clr_last = 0;
  logic        chk_clr = 1'b0;
  logic [11:0] clr_next = 12'hF00;
  logic        tb_we = 1'b0;
  logic [11:0] tb_waddr = 12'd0;
  logic [7:0]  tb_wdata = 8'h00;

  int          checks = 0, failures = 0;
  int          t_acc = 0, lat = 0;
  logic        col_s = 1'b0;

  chip8_sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .pos_x(pos_x), .pos_y(pos_y), .rows(rows), .sprite_addr(sprite_addr),
    .busy(busy), .done(done), .collision(collision),
    .gpu_read(gpu_read), .gpu_read_addr(gpu_read_addr),
    .gpu_read_data(rdata_r), .gpu_read_ack(ack_r),
    .gpu_write(gpu_write), .gpu_write_addr(gpu_write_addr), .gpu_write_data(gpu_write_data)
  );

  always #5 clk = ~clk;

  // Memory model: reads ack one cycle after the strobe; also tallies bus activity.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_r   <= gpu_read;
    rdata_r <= mem[gpu_read_addr];
    if (gpu_read) rd_count <= rd_count + 1;
    if (gpu_read && gpu_write) both_count <= both_count + 1;
    if (gpu_write) begin
      mem[gpu_write_addr] <= gpu_write_data;
      wr_count <= wr_count + 1;
      if (chk_clr) begin
        if (gpu_write_addr !== clr_next || gpu_write_data !== 8'h00 ||
            (clr_next != 12'hF00 && cyc != clr_last + 1))
          seq_err <= seq_err + 1;
        clr_next <= clr_next + 12'd1;
        clr_last <= cyc;
      end
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic fill_fb(input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tb_waddr = 12'hF00 + 12'(k); tb_wdata = d;
      @(negedge clk);
    end
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic is_clr, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] n, input logic [11:0] a);
    @(negedge clk);
    pos_x = x; pos_y = y; rows = n; sprite_addr = a;
    if (is_clr) clear = 1'b1; else start = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    lat = -1;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        lat = cyc - t_acc; col_s = collision;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, collision, gpu_read, gpu_write} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {busy, done, collision, gpu_read, gpu_write});
    end
    checks++;
    if ({gpu_read_addr, gpu_write_addr, gpu_write_data} !== 32'h0) begin
      failures++; $display("FAIL reset_bus: got %h want 0", {gpu_read_addr, gpu_write_addr, gpu_write_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic check_byte(input string nm, input logic [11:0] a, input logic [7:0] e);
    checks++;
    if (mem[a] !== e) begin
      failures++; $display("FAIL %s: mem[%h] got %h want %h", nm, a, mem[a], e);
    end
  endtask

  task automatic test_font0(input logic redraw);
    logic [7:0] exp_v [0:4] = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    issue(1'b0, 8'd0, 8'd0, 4'd5, 12'h014);
    wait_done(100);
    for (int r = 0; r < 5; r++)
      check_byte(redraw ? "redraw_row" : "font0_row", 12'hF00 + 12'(r * 8), redraw ? 8'h00 : exp_v[r]);
    checks++;
    if (col_s !== redraw) begin
      failures++; $display("FAIL font0_collision: got %b want %b", col_s, redraw);
    end
    checks++;
    if (lat !== 27) begin
      failures++; $display("FAIL font0_latency: got %0d want 27", lat);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL font0_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_clear;
    int rd0, wr0, nz;
    fill_fb(8'hAA);
    rd0 = rd_count; wr0 = wr_count;
    clr_next = 12'hF00; chk_clr = 1'b1;
    issue(1'b1, 8'd0, 8'd0, 4'd1, 12'h030);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    chk_clr = 1'b0;
    checks++;
    if (lat !== 257) begin failures++; $display("FAIL clear_latency: got %0d want 257", lat); end
    checks++;
    if (seq_err !== 0) begin failures++; $display("FAIL clear_sequence: got %0d bad writes want 0", seq_err); end
    checks++;
    if (wr_count - wr0 !== 256) begin failures++; $display("FAIL clear_writes: got %0d want 256", wr_count - wr0); end
    nz = 0;
    for (int k = 0; k < 256; k++) if (mem[12'hF00 + 12'(k)] !== 8'h00) nz++;
    checks++;
    if (nz !== 0) begin failures++; $display("FAIL clear_contents: got %0d nonzero bytes want 0", nz); end
    checks++;
    if (col_s !== 1'b0) begin failures++; $display("FAIL clear_collision: got %b want 0", col_s); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_count - rd0 !== 0) begin
      failures++; $display("FAIL clear_ignores_start: busy=%b reads=%0d want 0 0", busy, rd_count - rd0);
    end
  endtask

  task automatic test_rows0;
    int rd0, wr0;
    rd0 = rd_count; wr0 = wr_count;
    issue(1'b0, 8'd5, 8'd5, 4'd0, 12'h014);
    wait_done(20);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL rows0_latency: got %0d want 2", lat); end
    checks++;
    if (rd_count - rd0 !== 0 || wr_count - wr0 !== 0) begin
      failures++; $display("FAIL rows0_access: reads=%0d writes=%0d want 0 0", rd_count - rd0, wr_count - wr0);
    end
    checks++;
    if (col_s !== 1'b0) begin failures++; $display("FAIL rows0_collision: got %b want 0", col_s); end
  endtask

  task automatic test_draw1(input string nm, input logic [7:0] x, input logic [7:0] y,
                            input int exp_lat, input int exp_wr);
    int wr0;
    fill_fb(8'h00);
    wr0 = wr_count;
    issue(1'b0, x, y, 4'd1, 12'h030);
    wait_done(100);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat); end
    checks++;
    if (wr_count - wr0 !== exp_wr) begin
      failures++; $display("FAIL %s_writes: got %0d want %0d", nm, wr_count - wr0, exp_wr);
    end
    checks++;
    if (col_s !== 1'b0) begin failures++; $display("FAIL %s_collision: got %b want 0", nm, col_s); end
  endtask

  task automatic test_straddle;
    test_draw1("straddle", 8'd3, 8'd1, 10, 2);
    check_byte("straddle_left", 12'hF08, 8'h1F);
    check_byte("straddle_right", 12'hF09, 8'hE0);
  endtask

  task automatic test_clip_right;
    test_draw1("clip_right", 8'd60, 8'd0, 7, 1);
    check_byte("clip_right_byte", 12'hF07, 8'h0F);
    check_byte("clip_right_nowrap", 12'hF08, 8'h00);
  endtask

  task automatic test_wrap;
    test_draw1("wrap", 8'd70, 8'd33, 10, 2);
    check_byte("wrap_left", 12'hF08, 8'h03);
    check_byte("wrap_right", 12'hF09, 8'hFC);
  endtask

  task automatic test_clip_bottom;
    int wr0;
    fill_fb(8'h00);
    wr0 = wr_count;
    issue(1'b0, 8'd0, 8'd30, 4'd5, 12'h014);
    wait_done(100);
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL clip_bottom_latency: got %0d want 12", lat); end
    checks++;
    if (wr_count - wr0 !== 2) begin failures++; $display("FAIL clip_bottom_writes: got %0d want 2", wr_count - wr0); end
    check_byte("clip_bottom_row30", 12'hFF0, 8'hF0);
    check_byte("clip_bottom_row31", 12'hFF8, 8'h90);
    check_byte("clip_bottom_nowrap", 12'hF00, 8'h00);
  endtask

  task automatic test_reset_mid;
    int seen_done;
    fill_fb(8'h00);
    issue(1'b0, 8'd0, 8'd0, 4'd5, 12'h014);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    seen_done = 0;
    repeat (3) begin @(negedge clk); if (done) seen_done++; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (done) seen_done++; end
    checks++;
    if (seen_done !== 0) begin failures++; $display("FAIL reset_mid_done: got %0d pulses want 0", seen_done); end
    check_byte("reset_mid_row0", 12'hF00, 8'hF0);
    check_byte("reset_mid_row1", 12'hF08, 8'h90);
    check_byte("reset_mid_row2", 12'hF10, 8'h00);
    check_byte("reset_mid_row3", 12'hF18, 8'h00);
    check_byte("reset_mid_row4", 12'hF20, 8'h00);
  endtask

  initial begin
    test_reset;
    fill_fb(8'h00);
    poke(12'h014, 8'hF0); poke(12'h015, 8'h90); poke(12'h016, 8'h90);
    poke(12'h017, 8'h90); poke(12'h018, 8'hF0); poke(12'h030, 8'hFF);
    test_font0(1'b0);
    test_font0(1'b1);
    test_clear;
    test_rows0;
    test_straddle;
    test_clip_right;
    test_clip_bottom;
    test_wrap;
    test_reset_mid;
    checks++;
    if (both_count !== 0) begin failures++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_count); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
